// File: rtl/phy_serial_sync_rx.sv
// Serial receive front end for the 4-lane PHY link.
// Hunts for COM alignment bit by bit, confirms lock over COM_COUNT byte-aligned
// COMs, then decodes bytes and hands them out round-robin to lanes 0..3.
module phy_serial_sync_rx #(
  parameter logic [7:0]  COM_CHAR  = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR = 8'h7C,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic       i_clk_32f,
  input  logic       i_reset,
  input  logic       i_serial_in,
  output logic [7:0] o_byte_out,
  output logic       o_byte_valid,
  output logic [1:0] o_lane_sel,
  output logic       o_active,
  output logic       o_idle_out
);

  localparam logic [3:0] ComCount    = 4'(COM_COUNT);
  // A single COM is enough to lock, so HUNT skips COUNT entirely.
  localparam logic       LockOnFirst = (COM_COUNT <= 1);

  typedef enum logic [1:0] {StHunt, StCount, StActive} state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_shreg;
  logic [7:0] w_shreg_nxt;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_com_cnt;
  logic [3:0] w_com_inc;
  logic [7:0] r_byte_out;
  logic       r_byte_valid;
  logic [1:0] r_lane_sel;
  logic       r_last_com;
  logic       w_boundary;
  logic       w_is_com;
  logic       w_is_idle;
  logic       w_lock;

  assign w_shreg_nxt = {r_shreg[6:0], i_serial_in};
  assign w_boundary  = (r_bit_cnt == 3'd7);
  assign w_is_com    = (w_shreg_nxt == COM_CHAR);
  assign w_is_idle   = (w_shreg_nxt == IDLE_CHAR);
  assign w_com_inc   = r_com_cnt + 4'd1;
  assign w_lock      = (w_com_inc >= ComCount);

  // State register.
  always_ff @(posedge i_clk_32f) begin
    if (i_reset) begin
      r_state <= StHunt;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: bit-granular search, byte-aligned confirmation, then locked until reset.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StHunt: begin
        if (w_is_com) begin
          w_state_nxt = LockOnFirst ? StActive : StCount;
        end
      end
      StCount: begin
        if (w_boundary) begin
          if (!w_is_com) begin
            w_state_nxt = StHunt;
          end else if (w_lock) begin
            w_state_nxt = StActive;
          end
        end
      end
      StActive: w_state_nxt = StActive;
      default:  w_state_nxt = StHunt;
    endcase
  end

  // Outputs decoded from state; idle is forced while unlocked.
  always_comb begin
    o_active     = (r_state == StActive);
    o_idle_out   = (r_state != StActive) || r_last_com;
    o_byte_out   = r_byte_out;
    o_byte_valid = r_byte_valid;
    o_lane_sel   = r_lane_sel;
  end

  // Datapath: shift register, bit/COM counters, byte and lane registers.
  always_ff @(posedge i_clk_32f) begin
    if (i_reset) begin
      r_shreg      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_com_cnt    <= 4'd0;
      r_byte_out   <= 8'd0;
      r_byte_valid <= 1'b0;
      r_lane_sel   <= 2'd0;
      r_last_com   <= 1'b1;
    end else begin
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= r_bit_cnt + 3'd1;
      r_byte_valid <= 1'b0;
      // lane_sel shows the slot lane during the valid cycle, then moves on.
      if (r_byte_valid) begin
        r_lane_sel <= r_lane_sel + 2'd1;
      end
      unique case (r_state)
        StHunt: begin
          if (w_is_com) begin
            r_bit_cnt  <= 3'd0;
            r_com_cnt  <= 4'd1;
            r_lane_sel <= 2'd0;
            r_last_com <= 1'b1;
          end
        end
        StCount: begin
          if (w_boundary) begin
            if (w_is_com) begin
              r_com_cnt  <= w_lock ? ComCount : w_com_inc;
              r_lane_sel <= 2'd0;
              r_last_com <= 1'b1;
            end else begin
              r_com_cnt <= 4'd0;
            end
          end
        end
        StActive: begin
          if (w_boundary) begin
            if (w_is_com) begin
              // Frame marker: restart at lane 0, dropping any partial frame.
              r_lane_sel <= 2'd0;
              r_last_com <= 1'b1;
            end else if (w_is_idle) begin
              r_lane_sel <= r_lane_sel + 2'd1;
              r_last_com <= 1'b0;
            end else begin
              r_byte_out   <= w_shreg_nxt;
              r_byte_valid <= 1'b1;
              r_last_com   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
